// File: rtl/equiv_check_ctrl_if.sv
// Stimulus/response bundle between the equivalence controller and the
// golden/locked design pair. The controller takes the master side.
interface equiv_check_ctrl_if #(
  parameter int unsigned DW  = 16,
  parameter int unsigned NCH = 4
) ();
  logic [NCH*DW-1:0] gold_y;
  logic              gold_valid;
  logic [NCH*DW-1:0] dut_y;
  logic              dut_valid;
  logic              dut_rst;
  logic [NCH*DW-1:0] stim_x;
  logic              stim_next;

  modport master (
    input  gold_y, gold_valid, dut_y, dut_valid,
    output dut_rst, stim_x, stim_next
  );

  modport slave (
    output gold_y, gold_valid, dut_y, dut_valid,
    input  dut_rst, stim_x, stim_next
  );
endinterface

// File: rtl/equiv_check_ctrl.sv
// Equivalence-check run controller: resets a golden and a locked design,
// drives both with LFSR stimulus, compares their outputs after a fixed
// wait per trial and reports mismatch count / first failing trial.
module equiv_check_ctrl #(
  parameter int unsigned DW          = 16,
  parameter int unsigned NCH         = 4,
  parameter int unsigned WAIT_CYC    = 500,
  parameter int unsigned NTRIALS     = 30,
  parameter int unsigned CW          = 8,
  parameter logic [31:0] SEED        = 32'hACE1_2468,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NCH-1:0]          ch_mask,
  equiv_check_ctrl_if.master      bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CW-1:0]           err_count,
  output logic [15:0]             first_err_trial
);

  localparam int unsigned WCW  = $clog2(WAIT_CYC + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003; // x^32+x^22+x^2+x+1

  typedef enum logic [2:0] {
    IDLE, RST_DUT, SETTLE, LOAD, WAIT, CHECK, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rst_ph_q;
  logic [WCW-1:0]    wait_cnt_q;
  logic [15:0]       trial_q;
  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_walk;
  logic [NCH*DW-1:0] stim_d;
  logic              mismatch;
  logic              last_trial;
  logic [CW-1:0]     err_inc;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Next stimulus word: channel k takes the LFSR state after k+1 steps.
  always_comb begin
    lfsr_walk = lfsr_q;
    stim_d    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      lfsr_walk = lfsr_step(lfsr_walk);
      stim_d[k*DW +: DW] = lfsr_walk[DW-1:0];
    end
  end

  // Trial verdict: valid disagreement or any enabled channel differing.
  always_comb begin
    mismatch = (bus.gold_valid != bus.dut_valid);
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_mask[k] && (bus.gold_y[k*DW +: DW] != bus.dut_y[k*DW +: DW]))
        mismatch = 1'b1;
    end
  end

  assign last_trial = (trial_q == 16'(NTRIALS - 1));
  assign err_inc    = (err_count == '1) ? err_count : err_count + CW'(1);

  // Next-state decode; abort from any active state wins over everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RST_DUT;
      RST_DUT: if (rst_ph_q) state_d = SETTLE;
      SETTLE:  state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (wait_cnt_q == '0) state_d = CHECK;
      CHECK:   state_d = (last_trial || (STOP_ON_ERR && mismatch)) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE))
      state_d = IDLE;
  end

  // State, stimulus, trial bookkeeping and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rst_ph_q        <= 1'b0;
      wait_cnt_q      <= '0;
      trial_q         <= '0;
      lfsr_q          <= SEED;
      bus.stim_x      <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_trial <= '1;
    end else begin
      state_q  <= state_d;
      rst_ph_q <= (state_q == RST_DUT);
      if ((state_q == IDLE) && start) begin
        lfsr_q          <= SEED;
        trial_q         <= '0;
        err_count       <= '0;
        first_err_trial <= '1;
      end
      if (state_d == LOAD) begin
        bus.stim_x <= stim_d;
        lfsr_q     <= lfsr_walk;
      end
      if (state_q == LOAD)
        wait_cnt_q <= WCW'(WAIT_CYC - 1);
      else if (state_q == WAIT)
        wait_cnt_q <= wait_cnt_q - WCW'(1);
      if ((state_q == CHECK) && !abort) begin
        trial_q <= trial_q + 16'd1;
        if (mismatch) begin
          err_count <= err_inc;
          if (err_count == '0)
            first_err_trial <= trial_q;
        end
        // pass must reflect this CHECK, so it is taken from the verdict directly
        if (state_d == DONE)
          pass <= !mismatch && (err_count == '0);
      end
      if (abort && (state_q != IDLE))
        pass <= 1'b0;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.stim_next = (state_q == LOAD);
  assign bus.dut_rst   = rst || (state_q == RST_DUT);

endmodule

// File: tb/tb_equiv_check_ctrl.sv
// Scoreboard bench for equiv_check_ctrl: three instances cover the default
// configuration, stop-on-error and a narrow saturating error counter.
module tb_equiv_check_ctrl;
  localparam int unsigned DW   = 16;
  localparam int unsigned NCH  = 4;
  localparam int          WC   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, abort;
  logic [NCH-1:0] ch_mask;
  logic           start_v [3];
  int             fmode;
  logic           fault_on;

  logic [NCH*DW-1:0] stim_v [3];
  logic              next_v [3], drst_v [3], busy_v [3], done_v [3], pass_v [3];
  logic [7:0]        err_v  [3];
  logic [15:0]       fet_v  [3];
  logic [7:0]        err0, err1;
  logic [1:0]        err2;
  logic              last_pass [3];

  int n_checks = 0;
  int n_errors = 0;

  // Locked-design model: echo of stimulus with selectable fault.
  function automatic logic [NCH*DW-1:0] fault_y(input logic [NCH*DW-1:0] s,
                                                input int fm, input logic fon);
    logic [NCH*DW-1:0] one;
    one = 1;
    if (fm == 1 && fon) return s ^ (one << (2*DW));
    if (fm == 3) return ~s;
    return s;
  endfunction

  equiv_check_ctrl_if #(.DW(DW), .NCH(NCH)) bus0 ();
  equiv_check_ctrl_if #(.DW(DW), .NCH(NCH)) bus1 ();
  equiv_check_ctrl_if #(.DW(DW), .NCH(NCH)) bus2 ();

  assign bus0.gold_y = bus0.stim_x;  assign bus0.gold_valid = 1'b1;
  assign bus1.gold_y = bus1.stim_x;  assign bus1.gold_valid = 1'b1;
  assign bus2.gold_y = bus2.stim_x;  assign bus2.gold_valid = 1'b1;
  assign bus0.dut_y = fault_y(bus0.stim_x, fmode, fault_on);  assign bus0.dut_valid = (fmode != 2);
  assign bus1.dut_y = fault_y(bus1.stim_x, fmode, fault_on);  assign bus1.dut_valid = (fmode != 2);
  assign bus2.dut_y = fault_y(bus2.stim_x, fmode, fault_on);  assign bus2.dut_valid = (fmode != 2);

  assign stim_v[0] = bus0.stim_x;    assign stim_v[1] = bus1.stim_x;    assign stim_v[2] = bus2.stim_x;
  assign next_v[0] = bus0.stim_next; assign next_v[1] = bus1.stim_next; assign next_v[2] = bus2.stim_next;
  assign drst_v[0] = bus0.dut_rst;   assign drst_v[1] = bus1.dut_rst;   assign drst_v[2] = bus2.dut_rst;
  assign err_v[0] = err0;  assign err_v[1] = err1;  assign err_v[2] = {6'b0, err2};

  equiv_check_ctrl #(.DW(DW), .NCH(NCH), .WAIT_CYC(WC), .NTRIALS(3), .CW(8),
                     .SEED(SEED), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .ch_mask(ch_mask),
    .bus(bus0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err0), .first_err_trial(fet_v[0]));

  equiv_check_ctrl #(.DW(DW), .NCH(NCH), .WAIT_CYC(WC), .NTRIALS(3), .CW(8),
                     .SEED(SEED), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .ch_mask(ch_mask),
    .bus(bus1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err1), .first_err_trial(fet_v[1]));

  equiv_check_ctrl #(.DW(DW), .NCH(NCH), .WAIT_CYC(WC), .NTRIALS(6), .CW(2),
                     .SEED(SEED), .STOP_ON_ERR(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .ch_mask(ch_mask),
    .bus(bus2), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err2), .first_err_trial(fet_v[2]));

  typedef struct { int n; logic [NCH*DW-1:0] stim; } load_t;
  typedef struct { int n; logic pass; int err; int fet; } res_t;
  load_t load_q [$];
  res_t  res_q  [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run on instance idx; kill_n>0 aborts (or resets) during cycle kill_n.
  task automatic run(input int idx, input int trials, input int fm, input logic [3:0] mask,
                     input logic exp_pass, input int exp_err, input int exp_fet,
                     input int kill_n, input bit kill_rst);
    logic [31:0]       m;
    logic [NCH*DW-1:0] s;
    int                n;
    bit                fin;
    load_t             ld;
    res_t              r;
    fmode = fm; ch_mask = mask; fault_on = 1'b0;
    m = SEED; s = '0;
    for (int t = 0; t < trials; t++) begin
      for (int k = 0; k < NCH; k++) begin
        m = {1'b0, m[31:1]} ^ ({32{m[0]}} & TAPS);
        s[k*DW +: DW] = m[DW-1:0];
      end
      if (kill_n == 0 || 4 + t*(WC+2) <= kill_n)
        load_q.push_back('{n: 4 + t*(WC+2), stim: s});
    end
    if (kill_n == 0)
      res_q.push_back('{n: 4 + trials*(WC+2), pass: exp_pass, err: exp_err, fet: exp_fet});

    @(negedge clk); start_v[idx] = 1'b1;
    @(posedge clk); #1; start_v[idx] = 1'b0;
    n = 1; fin = 0;
    while (!fin && n <= 8 + trials*(WC+2)) begin
      @(negedge clk);
      if (n <= 3) check($sformatf("dut_rst_n%0d", n), drst_v[idx], n <= 2);
      if (n == 1) begin
        check("start_clr_err", err_v[idx], 0);
        check("start_clr_fet", fet_v[idx], 16'hFFFF);
        check("pass_hold", pass_v[idx], last_pass[idx]);
        check("busy_run", busy_v[idx], 1);
      end
      fault_on = (n >= 4 + (WC+2)) && (n < 4 + 2*(WC+2));
      if (next_v[idx]) begin
        if (load_q.size() == 0) check("load_unexpected_n", n, 0);
        else begin
          ld = load_q.pop_front();
          check("load_n", n, ld.n);
          check("stim_x", stim_v[idx], ld.stim);
        end
      end
      if (done_v[idx]) begin
        if (res_q.size() == 0) check("done_unexpected_n", n, 0);
        else begin
          r = res_q.pop_front();
          check("done_n", n, r.n);
          check("pass", pass_v[idx], r.pass);
          check("err_count", err_v[idx], r.err);
          check("first_err_trial", fet_v[idx], r.fet);
        end
        fin = 1;
      end
      if (n == kill_n) begin
        if (kill_rst) rst = 1'b1; else abort = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0; abort = 1'b0; n++;
      if (kill_n != 0 && n == kill_n + 1) begin
        check("kill_busy", busy_v[idx], 0);
        check("kill_done", done_v[idx], 0);
        check("kill_pass", pass_v[idx], 0);
        fin = 1;
      end
    end
    check("busy_after", busy_v[idx], 0);
    check("loads_pending", load_q.size(), 0);
    check("results_pending", res_q.size(), 0);
    load_q.delete(); res_q.delete(); fault_on = 1'b0;
    last_pass[idx] = (kill_n != 0) ? 1'b0 : exp_pass;
    if (kill_rst) foreach (last_pass[i]) last_pass[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; ch_mask = '1; fmode = 0; fault_on = 1'b0;
    foreach (start_v[i]) start_v[i] = 1'b0;
    foreach (last_pass[i]) last_pass[i] = 1'b0;
    start_v[0] = 1'b1;   // must be overridden by reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dut_rst", drst_v[0], 1);
    check("rst_busy", busy_v[0], 0);
    start_v[0] = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_busy", busy_v[i], 0);
      check("reset_done", done_v[i], 0);
      check("reset_pass", pass_v[i], 0);
      check("reset_err", err_v[i], 0);
      check("reset_fet", fet_v[i], 16'hFFFF);
      check("reset_stim_x", stim_v[i], 0);
      check("reset_stim_next", next_v[i], 0);
      check("reset_dut_rst", drst_v[i], 0);
    end

    run(0, 3, 0, 4'hF, 1'b1, 0, 16'hFFFF, 0, 1'b0);  // clean run
    run(0, 3, 1, 4'hF, 1'b0, 1, 1,        0, 1'b0);  // ch2 fault in trial 1
    run(0, 3, 1, 4'hB, 1'b1, 0, 16'hFFFF, 0, 1'b0);  // same fault, ch2 masked
    run(1, 1, 2, 4'hF, 1'b0, 1, 0,        0, 1'b0);  // stop on first error
    run(2, 6, 3, 4'hF, 1'b0, 3, 0,        0, 1'b0);  // saturating counter
    run(0, 3, 0, 4'hF, 1'b0, 0, 0,       12, 1'b0);  // abort mid-run
    run(0, 3, 0, 4'hF, 1'b0, 0, 0,        5, 1'b1);  // reset mid-run
    run(0, 3, 0, 4'hF, 1'b1, 0, 16'hFFFF, 0, 1'b0);  // fresh run after reset

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/equiv_check_ctrl.md
EQUIV_CHECK_CTRL -- requirements
Module: equiv_check_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DW, 16, data width per channel (1..32).
  NCH, 4, number of stimulus/response channels (1..8).
  WAIT_CYC, 500, cycles between stimulus pulse and compare (>=1).
  NTRIALS, 30, trials per run (1..65535).
  CW, 8, error counter width.
  SEED, 32'hACE1_2468, LFSR seed (nonzero).
  STOP_ON_ERR, 0, 1 = end run at first mismatch.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  rst  in  1  reset, synchronous, active-high.
  start  in  1  begin run (sampled in IDLE only).
  abort  in  1  cancel run, return to IDLE.
  ch_mask  in  NCH  1 = compare channel k.
  gold_y  in  NCH*DW  golden design outputs, channel k at [k*DW +: DW].
  gold_valid  in  1  golden next_out.
  dut_y  in  NCH*DW  locked design outputs.
  dut_valid  in  1  locked next_out.
  dut_rst  out  1  reset to both designs.
  stim_x  out  NCH*DW  stimulus to both designs.
  stim_next  out  1  next strobe to both designs.
  busy  out  1  run in progress.
  done  out  1  one-cycle run-complete pulse.
  pass  out  1  last completed run had zero mismatches.
  err_count  out  CW  mismatching trials in current/last run.
  first_err_trial  out  16  index of first mismatching trial; all-ones = none.

Function
REQ-003 States SHALL be IDLE, RST_DUT, SETTLE, LOAD, WAIT, CHECK, DONE; all outputs Moore-decoded from registers.
REQ-004 Cycle n SHALL be counted from the edge that samples start=1 in IDLE; RST_DUT at n=1,2; SETTLE at n=3.
REQ-005 Trial t (0-based) SHALL occupy LOAD at n=4+t*(WAIT_CYC+2), WAIT for WAIT_CYC cycles, CHECK at n=4+t*(WAIT_CYC+2)+WAIT_CYC+1.
REQ-006 dut_rst SHALL be 1 in RST_DUT and whenever rst=1, else 0.
REQ-007 stim_next SHALL be 1 exactly during LOAD.
REQ-008 stim_x SHALL update on the edge entering LOAD and hold until the next LOAD.
REQ-009 Stimulus SHALL come from a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, loaded with SEED on start; per LOAD, channel k gets low DW bits of the LFSR after k+1 steps; LFSR advances NCH steps per LOAD.
REQ-010 A trial mismatches in CHECK iff gold_valid!=dut_valid, or gold_y and dut_y differ in any channel k with ch_mask[k]=1.
REQ-011 On mismatch err_count SHALL increment, saturating at 2^CW-1.
REQ-012 On the first mismatch of a run, first_err_trial SHALL capture t.
REQ-013 After CHECK: go to DONE if t=NTRIALS-1 or (STOP_ON_ERR=1 and mismatch); otherwise go to LOAD.
REQ-014 DONE SHALL last one cycle with done=1, latch pass=(err_count==0 including this CHECK), then go to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 start in IDLE SHALL clear err_count to 0 and first_err_trial to all-ones; pass holds until next DONE.
REQ-018 abort=1 in any non-IDLE state SHALL go to IDLE next edge with no done and pass=0; abort beats start/CHECK transitions.

Reset
REQ-019 rst=1 SHALL override abort/start and force IDLE with stim_x=0, stim_next=0, busy=0, done=0, pass=0, err_count=0, first_err_trial=all-ones, LFSR=SEED.
REQ-020 rst asserted mid-run SHALL discard the run, no done pulse.

Verification
REQ-021 NTRIALS=3, WAIT_CYC=4, gold=dut tied: start -> dut_rst n=1..2, stim_next at n=4,10,16, done at n=22, pass=1, err_count=0, first_err_trial=16'hFFFF.
REQ-022 Same, dut_y channel 2 bit 0 forced inverted in trial 1, ch_mask=4'hF -> err_count=1, first_err_trial=1, pass=0, done n=22.
REQ-023 Same fault, ch_mask=4'hB -> pass=1, err_count=0.
REQ-024 STOP_ON_ERR=1, dut_valid stuck 0 with gold_valid=1 -> mismatch at CHECK n=9, done n=10, err_count=1, first_err_trial=0.
REQ-025 CW=2, NTRIALS=6, all trials mismatch -> err_count saturates at 3, pass=0.
REQ-026 abort at n=12, then rst at n=5 of next run -> both IDLE next edge, no done, busy=0; stim_x of next run's first LOAD matches reference LFSR model from SEED.
